// File: rtl/shift_rows_serial_if.sv
// rtl/shift_rows_serial_if.sv - byte streams in and out of the ShiftRows stage
// Purpose: groups the load stream (d_in/in_valid/in_ready/inv) and the drain
//          stream (d_out/out_valid/out_ready/out_col_start/out_last).
// Modports:
//   master - upstream/downstream side (drives d_in, in_valid, inv, out_ready)
//   slave  - shift_rows_serial side (drives in_ready, d_out, out_valid, flags)
interface shift_rows_serial_if #(
   parameter int DW = 8
);
   logic [DW-1:0] d_in;
   logic          in_valid;
   logic          in_ready;
   logic          inv;
   logic [DW-1:0] d_out;
   logic          out_valid;
   logic          out_ready;
   logic          out_col_start;
   logic          out_last;

   modport master (
      output d_in, in_valid, inv, out_ready,
      input  in_ready, d_out, out_valid, out_col_start, out_last
   );

   modport slave (
      input  d_in, in_valid, inv, out_ready,
      output in_ready, d_out, out_valid, out_col_start, out_last
   );
endinterface

// File: rtl/shift_rows_serial.sv
// rtl/shift_rows_serial.sv - byte-serial AES ShiftRows / InvShiftRows stage
// Purpose: buffers a 16-byte AES state arriving column-major, one byte per
//          cycle, and re-emits it column-major in row-shifted order.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous reset, active high
//   s    - shift_rows_serial_if.slave: d_in/in_valid/in_ready/inv load side,
//          d_out/out_valid/out_ready/out_col_start/out_last drain side
// Build option: SHIFT_ROWS_PINGPONG_EN selects two ping-pong banks so the
//          next block loads while the current one drains; undefined gives a
//          single bank (load, then drain, then load again).
module shift_rows_serial #(
   parameter int DW = 8
) (
   input  logic                clk,
   input  logic                rst,
   shift_rows_serial_if.slave  s
);

`ifdef SHIFT_ROWS_PINGPONG_EN
   localparam int   NB        = 2;
   localparam logic BANK_FLIP = 1'b1;
`else
   localparam int   NB        = 1;
   localparam logic BANK_FLIP = 1'b0;
`endif

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_t;

   logic [DW-1:0] mem [NB][16];
   bank_state_t   bank_st [NB];
   logic          bank_mode [NB];
   logic [3:0]    wr_cnt;
   logic [3:0]    rd_cnt;
   logic          wr_bank;
   logic          rd_bank;

   logic          load;
   logic          drain;
   logic          out_valid_i;
   logic [DW-1:0] rd_byte;

   // Output index k = 4c + r reads the input byte at row r, column
   // (c + r) mod 4 for ShiftRows, (c - r) mod 4 for InvShiftRows.
   // The 2-bit column sum wraps naturally.
   function automatic logic [3:0] src_idx(input logic [3:0] k, input logic m);
      logic [1:0] r;
      logic [1:0] c;
      logic [1:0] sc;
      r  = k[1:0];
      c  = k[3:2];
      sc = m ? (c - r) : (c + r);
      return {sc, r};
   endfunction

   assign out_valid_i = (bank_st[rd_bank] == BANK_FULL);
   assign load        = s.in_valid && s.in_ready;
   assign drain       = out_valid_i && s.out_ready;
   assign rd_byte     = mem[rd_bank][src_idx(rd_cnt, bank_mode[rd_bank])];

   assign s.in_ready      = (bank_st[wr_bank] == BANK_EMPTY);
   assign s.out_valid     = out_valid_i;
   // d_out is forced to zero while idle so a drained bank never shows stale data
   assign s.d_out         = out_valid_i ? rd_byte : '0;
   assign s.out_col_start = out_valid_i && (rd_cnt[1:0] == 2'd0);
   assign s.out_last      = out_valid_i && (rd_cnt == 4'd15);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt  <= 4'd0;
         rd_cnt  <= 4'd0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         for (int b = 0; b < NB; b++) begin
            bank_st[b]   <= BANK_EMPTY;
            bank_mode[b] <= 1'b0;
            for (int i = 0; i < 16; i++) begin
               mem[b][i] <= '0;
            end
         end
      end else begin
         if (load) begin
            mem[wr_bank][wr_cnt] <= s.d_in;
            if (wr_cnt == 4'd0) begin
               bank_mode[wr_bank] <= s.inv;
            end
            wr_cnt <= wr_cnt + 4'd1;
            if (wr_cnt == 4'd15) begin
               bank_st[wr_bank] <= BANK_FULL;
               wr_bank          <= wr_bank ^ BANK_FLIP;
            end
         end
         // Load completion and drain completion hit different banks when both
         // happen together (ping-pong only), so both updates land.
         if (drain) begin
            rd_cnt <= rd_cnt + 4'd1;
            if (rd_cnt == 4'd15) begin
               bank_st[rd_bank] <= BANK_EMPTY;
               rd_bank          <= rd_bank ^ BANK_FLIP;
            end
         end
      end
   end

endmodule

// File: tb/tb_shift_rows_serial.sv
// tb/tb_shift_rows_serial.sv - scoreboard bench for shift_rows_serial
module tb_shift_rows_serial;
   localparam int DW = 8;
   typedef logic [DW-1:0] blk_t [16];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   shift_rows_serial_if #(.DW(DW)) intf();
   shift_rows_serial #(.DW(DW)) dut (.clk(clk), .rst(rst), .s(intf));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int in_lo_cnt = 0;
   int last_acc_cyc = 0;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] got_q [$];
   logic          got_cs_q [$];
   logic          got_last_q [$];
   int            got_cyc_q [$];

   int fwd_tab [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
   int inv_tab [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

   blk_t appb_in  = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                      8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
   blk_t appb_out = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                      8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};

   always @(posedge clk) cyc <= cyc + 1;

   // Capture accepted output bytes; tasks compare them against exp_q.
   always @(negedge clk) begin
      if (!rst && intf.out_valid && intf.out_ready) begin
         got_q.push_back(intf.d_out);
         got_cs_q.push_back(intf.out_col_start);
         got_last_q.push_back(intf.out_last);
         got_cyc_q.push_back(cyc);
      end
      if (!rst && intf.in_valid && !intf.in_ready) in_lo_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
      $fatal(1);
   end

   task automatic clear_queues();
      exp_q.delete();
      got_q.delete();
      got_cs_q.delete();
      got_last_q.delete();
      got_cyc_q.delete();
   endtask

   task automatic push_model(input blk_t b, input logic m);
      for (int k = 0; k < 16; k++) exp_q.push_back(m ? b[inv_tab[k]] : b[fwd_tab[k]]);
   endtask

   task automatic send_byte(input logic [DW-1:0] b, input logic iv);
      int n;
      intf.d_in = b;
      intf.inv = iv;
      intf.in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!intf.in_ready && n < 200);
      if (!intf.in_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout got=in_ready_low want=accept byte=%h", b);
      end
      @(posedge clk);
      #1;
      intf.in_valid = 1'b0;
      last_acc_cyc = cyc;
   endtask

   task automatic send_block(input blk_t b, input logic iv, input bit gaps);
      for (int k = 0; k < 16; k++) begin
         send_byte(b[k], iv);
         if (gaps) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_outputs(input int n);
      int t;
      t = 0;
      while (got_q.size() < n && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (got_q.size() < n) begin
         total++;
         bad++;
         $display("FAIL output_timeout got=%0d want=%0d bytes", got_q.size(), n);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_queues();
   endtask

   task automatic test_reset();
      intf.d_in = '0;
      intf.in_valid = 1'b0;
      intf.inv = 1'b0;
      intf.out_ready = 1'b1;
      do_reset();
      total++;
      if (intf.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", intf.out_valid); end
      total++;
      if (intf.out_col_start !== 1'b0) begin bad++; $display("FAIL reset_col_start got=%b want=0", intf.out_col_start); end
      total++;
      if (intf.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", intf.out_last); end
      total++;
      if (intf.d_out !== 8'h00) begin bad++; $display("FAIL reset_d_out got=%h want=00", intf.d_out); end
      total++;
      if (intf.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", intf.in_ready); end
   endtask

   task automatic test_forward();
      logic [DW-1:0] e;
      clear_queues();
      for (int k = 0; k < 16; k++) exp_q.push_back(appb_out[k]);
      intf.out_ready = 1'b1;
      send_block(appb_in, 1'b0, 1'b0);
      wait_outputs(16);
      total++;
      if (got_cyc_q.size() > 0 && got_cyc_q[0] !== last_acc_cyc) begin
         bad++;
         $display("FAIL fwd_latency got=%0d want=%0d", got_cyc_q[0], last_acc_cyc);
      end
      for (int k = 0; k < 16 && got_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         total++;
         if (got_q[0] !== e) begin bad++; $display("FAIL fwd_byte%0d got=%h want=%h", k, got_q[0], e); end
         total++;
         if (got_cs_q[0] !== ((k % 4) == 0)) begin bad++; $display("FAIL fwd_col_start%0d got=%b want=%b", k, got_cs_q[0], (k % 4) == 0); end
         total++;
         if (got_last_q[0] !== (k == 15)) begin bad++; $display("FAIL fwd_last%0d got=%b want=%b", k, got_last_q[0], k == 15); end
         void'(got_q.pop_front());
         void'(got_cs_q.pop_front());
         void'(got_last_q.pop_front());
      end
   endtask

   task automatic test_inverse();
      blk_t b;
      logic [DW-1:0] e;
      clear_queues();
      for (int k = 0; k < 16; k++) b[k] = 8'(k);
      push_model(b, 1'b1);
      send_block(b, 1'b1, 1'b0);
      for (int k = 0; k < 16; k++) exp_q.push_back(appb_in[k]);
      send_block(appb_out, 1'b1, 1'b0);
      wait_outputs(32);
      for (int k = 0; k < 32 && got_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         total++;
         if (got_q[0] !== e) begin bad++; $display("FAIL inv_byte%0d got=%h want=%h", k, got_q[0], e); end
         void'(got_q.pop_front());
      end
   endtask

   task automatic test_backpressure();
      blk_t b;
      logic [DW-1:0] e;
      clear_queues();
      for (int k = 0; k < 16; k++) b[k] = 8'(k);
      push_model(b, 1'b0);
      intf.out_ready = 1'b0;
      send_block(b, 1'b0, 1'b1);
      intf.out_ready = 1'b1;
      wait_outputs(5);
      intf.out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         total++;
         if (intf.d_out !== 8'h09 || intf.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold got=%h/%b want=09/1", intf.d_out, intf.out_valid);
         end
         @(posedge clk);
      end
      #1;
      intf.out_ready = 1'b1;
      wait_outputs(16);
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (got_q.size() !== 16) begin bad++; $display("FAIL bp_count got=%0d want=16", got_q.size()); end
      for (int k = 0; k < 16 && got_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         total++;
         if (got_q[0] !== e) begin bad++; $display("FAIL bp_byte%0d got=%h want=%h", k, got_q[0], e); end
         void'(got_q.pop_front());
      end
   endtask

   task automatic test_back_to_back();
      blk_t b1;
      blk_t b2;
      logic [DW-1:0] e;
      int period;
      int want_period;
      int want_lo;
      clear_queues();
      for (int k = 0; k < 16; k++) begin
         b1[k] = 8'(16 + k);
         b2[k] = 8'($urandom_range(0, 255));
      end
      push_model(b1, 1'b0);
      push_model(b2, 1'b1);
      intf.out_ready = 1'b1;
      in_lo_cnt = 0;
      send_block(b1, 1'b0, 1'b0);
      send_block(b2, 1'b1, 1'b0);
      wait_outputs(32);
`ifdef SHIFT_ROWS_PINGPONG_EN
      want_period = 16;
      want_lo = 0;
`else
      want_period = 32;
      want_lo = 16;
`endif
      period = (got_cyc_q.size() >= 17) ? got_cyc_q[16] - got_cyc_q[0] : -1;
      total++;
      if (period !== want_period) begin bad++; $display("FAIL b2b_period got=%0d want=%0d", period, want_period); end
      total++;
      if (in_lo_cnt !== want_lo) begin bad++; $display("FAIL b2b_in_ready_low got=%0d want=%0d", in_lo_cnt, want_lo); end
      for (int k = 0; k < 32 && got_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         total++;
         if (got_q[0] !== e) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", k, got_q[0], e); end
         void'(got_q.pop_front());
      end
   endtask

   task automatic test_mode_latch();
      blk_t b;
      logic [DW-1:0] e;
      clear_queues();
      for (int k = 0; k < 16; k++) b[k] = 8'(8'hA0 + k);
      push_model(b, 1'b0);
      for (int k = 0; k < 16; k++) send_byte(b[k], (k >= 3));
      wait_outputs(16);
      for (int k = 0; k < 16 && got_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         total++;
         if (got_q[0] !== e) begin bad++; $display("FAIL latch_byte%0d got=%h want=%h", k, got_q[0], e); end
         void'(got_q.pop_front());
      end
   endtask

   task automatic test_mid_reset();
      blk_t b;
      logic [DW-1:0] e;
      clear_queues();
      intf.out_ready = 1'b1;
      for (int k = 0; k < 9; k++) send_byte(8'(8'h50 + k), 1'b1);
      do_reset();
      total++;
      if (intf.out_valid !== 1'b0 || intf.d_out !== 8'h00 || intf.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_load got=%b/%h/%b want=0/00/1", intf.out_valid, intf.d_out, intf.in_ready);
      end
      for (int k = 0; k < 16; k++) b[k] = 8'(8'hC0 + k);
      send_block(b, 1'b0, 1'b0);
      wait_outputs(6);
      do_reset();
      total++;
      if (intf.out_valid !== 1'b0 || intf.d_out !== 8'h00 || intf.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_drain got=%b/%h/%b want=0/00/1", intf.out_valid, intf.d_out, intf.in_ready);
      end
      for (int k = 0; k < 16; k++) b[k] = 8'(8'h30 + 3 * k);
      push_model(b, 1'b1);
      send_block(b, 1'b1, 1'b0);
      wait_outputs(16);
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (got_q.size() !== 16) begin bad++; $display("FAIL rst_fresh_count got=%0d want=16", got_q.size()); end
      for (int k = 0; k < 16 && got_q.size() > 0; k++) begin
         e = exp_q.pop_front();
         total++;
         if (got_q[0] !== e) begin bad++; $display("FAIL rst_fresh_byte%0d got=%h want=%h", k, got_q[0], e); end
         void'(got_q.pop_front());
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_inverse();
      test_backpressure();
      test_back_to_back();
      test_mode_latch();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/shift_rows_serial.md
Name: shift_rows_serial

Overview:
Byte-serial AES ShiftRows / InvShiftRows stage that sits directly upstream of the byte-serial MixColumns stage. It accepts the 16-byte state one byte per cycle in column-major order (s0..s15, s[r][c] = byte 4c+r). It buffers the block and re-emits it one byte per cycle in column-major order of the row-shifted state. The output stream drives the MixColumns byte input and its enable.

Parameters:
DW, 8, byte width of the data path (AES fixes this at 8; other values are for test only)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
d_in  input  DW  state byte in, column-major order
in_valid  input  1  d_in is valid this cycle
in_ready  output  1  stage can accept d_in this cycle
inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with byte 0 of each block
d_out  output  DW  shifted state byte out, column-major order
out_valid  output  1  d_out is valid; drives MixColumns enable
out_ready  input  1  downstream accepts d_out this cycle; tie high if unused
out_col_start  output  1  d_out is row 0 of a column (output index 0, 4, 8, 12)
out_last  output  1  d_out is output index 15

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst high at the clock edge) does the following:
  - Write and read counters go to 0 and all bank-full flags are cleared.
  - Buffer bytes are cleared to 0.
  - Output values after reset: out_valid=0, out_col_start=0, out_last=0, d_out=0, in_ready=1.
  - A partially loaded or partially drained block is discarded, with no output glitch afterwards.
- Load: a byte is accepted on in_valid && in_ready.
  - The byte is written to buffer[wr_cnt] and wr_cnt increments (4 bits, wraps 15 -> 0).
  - inv is latched into the bank's mode bit when wr_cnt==0.
  - Accepting byte 15 marks the bank full.
- Drain: while a full bank exists, out_valid=1.
  - d_out = buffer[src(rd_cnt, mode)], where k is the output index.
  - src for forward mode: src(k)=4*(((k>>2)+(k&3))&3)+(k&3). Sequence: 0,5,10,15, 4,9,14,3, 8,13,2,7, 12,1,6,11.
  - src for inverse mode: src(k)=4*(((k>>2)-(k&3))&3)+(k&3). Sequence: 0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3.
  - rd_cnt advances on out_valid && out_ready. When output index 15 is accepted, the bank is marked empty.
  - out_col_start = out_valid && rd_cnt[1:0]==0.
  - out_last = out_valid && rd_cnt==15.
- Latency: the first output is valid in the cycle after byte 15 is accepted.
- Stall: with out_ready low, d_out, out_valid and the flags hold steady and rd_cnt does not move.
- State machine per bank: EMPTY (loading) -> FULL (draining) -> EMPTY.
  - in_ready is high iff the write bank is EMPTY.
- in_valid while in_ready=0: the byte is ignored and not stored. The upstream stage must hold the byte.
- inv changes mid-block have no effect until the next block's byte 0.
- Simultaneous events: the last load of one bank and the last drain of the other in the same cycle are both honoured. With banks this produces no bubble.

Optional Feature:
SHIFT_ROWS_PINGPONG_EN
- Defined: two 16-byte banks, each with its own full flag and mode bit. Load and drain alternate banks, so load of block N+1 overlaps drain of block N.
  - With in_valid and out_ready held high, sustained throughput is 16 bytes per 16 cycles.
  - in_ready drops only when both banks are full.
- Undefined: a single bank.
  - in_ready=0 from acceptance of byte 15 until output index 15 is accepted.
  - With in_valid and out_ready held high, throughput is one block per 32 cycles.
  - The simultaneous load/drain case cannot occur.

Test Plan:
- Forward, FIPS-197 App. B round 1: inv=0, d_in = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> d_out = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5. First out_valid one cycle after the 16th accept; out_col_start on bytes d4/e0/b8/1e; out_last on e5.
- Inverse: inv=1, d_in = 00..0f -> 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03. Re-feed the forward App. B output with inv=1 and recover the original 16 bytes.
- Backpressure and gaps:
  - Forward, d_in=00..0f with in_valid toggling 1010..., and out_ready low for 3 cycles at output index 5.
  - Required: output exactly 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b; d_out holds 09 during the stall; no duplicates or drops.
- Throughput: two back-to-back blocks, in_valid and out_ready held high.
  - With SHIFT_ROWS_PINGPONG_EN: in_ready never low, and block 2 output follows block 1 with no bubble.
  - Without it: in_ready low for 16 cycles, and a 32-cycle block period.
- Mode latch: inv=0 at byte 0, then inv=1 from byte 3 onward -> the whole block uses the forward sequence.
- Reset mid-operation: assert rst after 9 bytes loaded and during a drain at output index 6.
  - Next cycle: out_valid=0, d_out=00, in_ready=1.
  - A fresh 16-byte block afterwards produces correct output with no leftover bytes.
